// File: rtl/pc_fetch_sequencer.sv
// RV32I fetch sequencer: owns the PC, issues single-outstanding req/ack fetches
// into a two-entry IF/ID output buffer and redirects on taken branches/jumps.
module pc_fetch_sequencer #(
    parameter int unsigned     XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            ex_valid,
    input  logic            pc_jump,
    input  logic [XLEN-1:0] target_addr,
    input  logic            stall,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_ack,
    input  logic [31:0]     imem_rdata,
    output logic            if_valid,
    output logic [31:0]     if_instr,
    output logic [XLEN-1:0] if_pc,
    output logic            flush,
    output logic            misalign_exc
);

    typedef enum logic [1:0] {StIdle, StFetch, StDiscard} state_e;

    localparam logic [XLEN-1:0] PcStep = XLEN'(4);

    state_e          state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic            req_q, req_d;
    logic [XLEN-1:0] addr_q, addr_d;
    logic            valid_q, valid_d;
    logic [31:0]     instr_q, instr_d;
    logic [XLEN-1:0] ifpc_q, ifpc_d;
    logic            skid_valid_q, skid_valid_d;
    logic [31:0]     skid_instr_q, skid_instr_d;
    logic [XLEN-1:0] skid_pc_q, skid_pc_d;
    logic            flush_q, flush_d;
    logic            misalign_q, misalign_d;

    logic jump, aligned, redirect, misaligned, ack, consume;

    assign jump       = ex_valid & pc_jump;
    assign aligned    = (target_addr[1:0] == 2'b00);
    assign redirect   = jump & aligned;
    assign misaligned = jump & ~aligned;
    // An ack with no request on the bus is ignored.
    assign ack        = imem_ack & req_q;
    assign consume    = valid_q & ~stall;

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        req_d        = req_q;
        addr_d       = addr_q;
        valid_d      = valid_q;
        instr_d      = instr_q;
        ifpc_d       = ifpc_q;
        skid_valid_d = skid_valid_q;
        skid_instr_d = skid_instr_q;
        skid_pc_d    = skid_pc_q;
        flush_d      = 1'b0;
        misalign_d   = 1'b0;

        // Decode takes the head entry; the skid entry (if any) moves up.
        if (consume) begin
            if (skid_valid_q) begin
                instr_d      = skid_instr_q;
                ifpc_d       = skid_pc_q;
                skid_valid_d = 1'b0;
            end else begin
                valid_d = 1'b0;
            end
        end

        if (redirect) begin
            flush_d      = 1'b1;
            valid_d      = 1'b0;
            skid_valid_d = 1'b0;
            if (req_q && !ack) begin
                // Orphaned request: keep the bus stable until its ack arrives.
                state_d = StDiscard;
                pc_d    = target_addr;
            end else begin
                state_d = StFetch;
                req_d   = 1'b1;
                addr_d  = target_addr;
                pc_d    = target_addr + PcStep;
            end
        end else begin
            flush_d    = misaligned;
            misalign_d = misaligned;
            unique case (state_q)
                StIdle: begin
                    state_d = StFetch;
                    req_d   = 1'b1;
                    addr_d  = pc_q;
                    pc_d    = pc_q + PcStep;
                end
                StFetch: begin
                    if (ack) begin
                        req_d = 1'b0;
                        if (!valid_d) begin
                            valid_d = 1'b1;
                            instr_d = imem_rdata;
                            ifpc_d  = addr_q;
                        end else begin
                            // Ack landed while decode is stalled on a full head.
                            skid_valid_d = 1'b1;
                            skid_instr_d = imem_rdata;
                            skid_pc_d    = addr_q;
                        end
                    end
                    if ((!req_q || ack) && (!valid_q || !stall)) begin
                        req_d  = 1'b1;
                        addr_d = pc_q;
                        pc_d   = pc_q + PcStep;
                    end
                end
                StDiscard: begin
                    if (ack) begin
                        state_d = StFetch;
                        req_d   = 1'b1;
                        addr_d  = pc_q;
                        pc_d    = pc_q + PcStep;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            pc_q         <= RESET_PC;
            req_q        <= 1'b0;
            addr_q       <= RESET_PC;
            valid_q      <= 1'b0;
            instr_q      <= '0;
            ifpc_q       <= '0;
            skid_valid_q <= 1'b0;
            skid_instr_q <= '0;
            skid_pc_q    <= '0;
            flush_q      <= 1'b0;
            misalign_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            req_q        <= req_d;
            addr_q       <= addr_d;
            valid_q      <= valid_d;
            instr_q      <= instr_d;
            ifpc_q       <= ifpc_d;
            skid_valid_q <= skid_valid_d;
            skid_instr_q <= skid_instr_d;
            skid_pc_q    <= skid_pc_d;
            flush_q      <= flush_d;
            misalign_q   <= misalign_d;
        end
    end

    assign imem_req     = req_q;
    assign imem_addr    = addr_q;
    assign if_valid     = valid_q;
    assign if_instr     = instr_q;
    assign if_pc        = ifpc_q;
    assign flush        = flush_q;
    assign misalign_exc = misalign_q;

endmodule
